// File: rtl/bist_pattern_gen.sv
// BIST stimulus generator: thermometer, walking-one, LFSR or switch-load patterns advanced on a divided tick.
// Define BIST_MISR_EN to add a response-compacting MISR that publishes a signature per completed sequence.
module bist_pattern_gen #(
  parameter int               WIDTH = 4,
  parameter int               DIV   = 10,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [1:0]                       mode,
  input  logic [WIDTH-1:0]                 sw,
  input  logic [WIDTH-1:0]                 resp,
  output logic [WIDTH-1:0]                 pat,
  output logic [$clog2(2*WIDTH+1)-1:0]     step,
  output logic                             seq_done,
  output logic [WIDTH-1:0]                 sig,
  output logic                             sig_valid
);

  localparam int SW = $clog2(2*WIDTH+1);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_THERM = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_LOAD  = 2'd3
  } mode_t;

  mode_t            mode_c;
  mode_t            mode_q;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic             restart;
  logic             wrap;
  logic [WIDTH-1:0] lfsr_next;

  assign mode_c    = mode_t'(mode);
  assign tick      = en && (cnt == CW'(DIV - 1));
  assign restart   = (mode_c != mode_q);
  assign lfsr_next = {pat[WIDTH-2:0], ^(pat & TAPS)};

  // wrap marks the tick that completes a sequence; a restart suppresses it
  always_comb begin
    wrap = 1'b0;
    if (tick && !restart) begin
      case (mode_c)
        MODE_THERM: wrap = (step == SW'(2 * WIDTH));
        MODE_WALK:  wrap = pat[WIDTH-1];
        MODE_LFSR:  wrap = (pat != '0) && (lfsr_next == SEED);
        default:    wrap = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_THERM;
      cnt      <= '0;
      pat      <= '0;
      step     <= '0;
      seq_done <= 1'b0;
    end else begin
      mode_q   <= mode_c;
      seq_done <= wrap;
      if (restart) begin
        cnt  <= '0;
        pat  <= (mode_c == MODE_LFSR) ? SEED : '0;
        step <= '0;
      end else begin
        if (!en || tick) cnt <= '0;
        else             cnt <= cnt + CW'(1);

        if (mode_c == MODE_LOAD) begin
          pat  <= sw;
          step <= '0;
        end else if (tick) begin
          case (mode_c)
            MODE_THERM: begin
              if (wrap) begin
                pat  <= '0;
                step <= '0;
              end else if (step < SW'(WIDTH)) begin
                pat  <= {1'b1, pat[WIDTH-1:1]};
                step <= step + SW'(1);
              end else begin
                pat  <= {pat[WIDTH-2:0], 1'b0};
                step <= step + SW'(1);
              end
            end
            MODE_WALK: begin
              if (pat == '0) begin
                pat <= WIDTH'(1);
              end else if (wrap) begin
                pat  <= '0;
                step <= '0;
              end else begin
                pat  <= pat << 1;
                step <= step + SW'(1);
              end
            end
            MODE_LFSR: begin
              // an all-zero register would lock the LFSR, so reseed instead
              if (pat == '0) begin
                pat  <= SEED;
                step <= '0;
              end else begin
                pat  <= lfsr_next;
                step <= wrap ? '0 : step + SW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef BIST_MISR_EN
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] misr_next;

  assign misr_next = {misr[WIDTH-2:0], ^(misr & TAPS)} ^ resp;

  // signature is the compacted response of one full sequence, then the MISR starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misr      <= '0;
      sig       <= '0;
      sig_valid <= 1'b0;
    end else begin
      sig_valid <= 1'b0;
      if (restart) begin
        misr <= '0;
      end else if (tick && (mode_c != MODE_LOAD)) begin
        if (wrap) begin
          sig       <= misr_next;
          sig_valid <= 1'b1;
          misr      <= '0;
        end else begin
          misr <= misr_next;
        end
      end
    end
  end
`else
  logic unused_resp;

  assign unused_resp = ^resp;
  assign sig         = '0;
  assign sig_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Self-checking bench for bist_pattern_gen: directed pattern checks plus randomized run against a behavioural model.
module tb_bist_pattern_gen;

  localparam int               W    = 4;
  localparam int               DIV  = 2;
  localparam logic [W-1:0]     SEED = 4'b0001;
  localparam logic [W-1:0]     TAPS = 4'b1100;
  localparam int               SW   = $clog2(2*W+1);

`ifdef BIST_MISR_EN
  localparam bit               MISR_ON      = 1'b1;
  localparam logic [W-1:0]     MISR_SIG_EXP = 4'b0100;
`else
  localparam bit               MISR_ON      = 1'b0;
  localparam logic [W-1:0]     MISR_SIG_EXP = 4'b0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  sw = '0;
  logic [W-1:0]  resp = '0;
  logic [W-1:0]  pat;
  logic [SW-1:0] step;
  logic          seq_done;
  logic [W-1:0]  sig;
  logic          sig_valid;

  int checks = 0;
  int failures = 0;

  bist_pattern_gen #(.WIDTH(W), .DIV(DIV), .SEED(SEED), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sw(sw), .resp(resp),
    .pat(pat), .step(step), .seq_done(seq_done), .sig(sig), .sig_valid(sig_valid)
  );

  always #5 clk = ~clk;

  // behavioural model: position-indexed patterns for modes 0/1, rule-level LFSR/MISR
  logic [W-1:0] m_pat = '0;
  int           m_step = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sig = '0;
  logic         m_sigv = 1'b0;
  int           m_cnt = 0;
  logic [1:0]   m_mode_q = 2'd0;
  int           m_pos = 0;
  logic [W-1:0] m_misr = '0;
  logic [W-1:0] m_nxt;
  logic         m_tick;

  function automatic logic [W-1:0] therm_pat(input int pos);
    int ones;
    logic [W-1:0] p;
    ones = (pos <= W) ? pos : 2*W - pos;
    p = '0;
    for (int i = 0; i < ones; i++) p[W-1-i] = 1'b1;
    return p;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pat = '0; m_step = 0; m_done = 1'b0; m_sig = '0; m_sigv = 1'b0;
      m_cnt = 0; m_mode_q = 2'd0; m_pos = 0; m_misr = '0;
    end else begin
      m_tick = en && (m_cnt == DIV - 1);
      m_done = 1'b0;
      m_sigv = 1'b0;
      if (mode != m_mode_q) begin
        m_pos = 0; m_cnt = 0; m_misr = '0; m_step = 0;
        m_pat = (mode == 2'd2) ? SEED : '0;
      end else begin
        m_cnt = (!en || m_tick) ? 0 : m_cnt + 1;
        case (mode)
          2'd0: if (m_tick) begin
            m_done = (m_pos == 2*W);
            m_pos  = m_done ? 0 : m_pos + 1;
            m_pat  = therm_pat(m_pos);
            m_step = m_pos;
          end
          2'd1: if (m_tick) begin
            m_done = (m_pos == W);
            m_pos  = m_done ? 0 : m_pos + 1;
            m_pat  = (m_pos == 0) ? '0 : (W'(1) << (m_pos - 1));
            m_step = (m_pos == 0) ? 0 : m_pos - 1;
          end
          2'd2: if (m_tick) begin
            if (m_pat == '0) begin
              m_pat = SEED;
              m_step = 0;
            end else begin
              m_nxt  = {m_pat[W-2:0], ^(m_pat & TAPS)};
              m_pat  = m_nxt;
              m_done = (m_nxt == SEED);
              m_step = m_done ? 0 : (m_step + 1) % (1 << SW);
            end
          end
          default: begin
            m_pat = sw;
            m_step = 0;
          end
        endcase
        if (MISR_ON && m_tick && mode != 2'd3) begin
          m_nxt = {m_misr[W-2:0], ^(m_misr & TAPS)} ^ resp;
          if (m_done) begin
            m_sig = m_nxt; m_sigv = 1'b1; m_misr = '0;
          end else begin
            m_misr = m_nxt;
          end
        end
      end
      m_mode_q = mode;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("model_pat", 32'(pat), 32'(m_pat));
    checkOutput("model_step", 32'(step), 32'(m_step));
    checkOutput("model_seq_done", 32'(seq_done), 32'(m_done));
    checkOutput("model_sig", 32'(sig), 32'(m_sig));
    checkOutput("model_sig_valid", 32'(sig_valid), 32'(m_sigv));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compareModel();
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic e, input logic [W-1:0] s, input logic [W-1:0] r);
    mode = m;
    en = e;
    sw = s;
    resp = r;
  endtask

  logic [W-1:0] therm_exp [9] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110,
                                  4'b1100, 4'b1000, 4'b0000, 4'b0000};
  logic [W-1:0] walk_exp [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [W-1:0] lfsr_exp [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                  4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

  initial begin
    applyStimulus(2'd0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("reset_pat", 32'(pat), 0);
    checkOutput("reset_step", 32'(step), 0);
    checkOutput("reset_seq_done", 32'(seq_done), 0);
    checkOutput("reset_sig", 32'(sig), 0);
    checkOutput("reset_sig_valid", 32'(sig_valid), 0);

    rst = 1'b1;
    applyStimulus(2'd0, 1'b1, '0, '0);
    for (int k = 0; k < 9; k++) begin
      runCycles(DIV);
      checkOutput("therm_pat", 32'(pat), 32'(therm_exp[k]));
      checkOutput("therm_done", 32'(seq_done), (k == 8) ? 1 : 0);
    end
    runCycles(DIV);
    checkOutput("therm_repeat", 32'(pat), 32'h8);

    applyStimulus(2'd1, 1'b1, '0, '0);
    runCycles(1);
    checkOutput("walk_restart", 32'(pat), 0);
    for (int k = 0; k < 5; k++) begin
      runCycles(DIV);
      checkOutput("walk_pat", 32'(pat), 32'(walk_exp[k]));
      checkOutput("walk_done", 32'(seq_done), (k == 4) ? 1 : 0);
    end

    applyStimulus(2'd0, 1'b1, '0, '0);
    runCycles(1);
    applyStimulus(2'd2, 1'b1, '0, '0);
    runCycles(1);
    checkOutput("lfsr_restart_pat", 32'(pat), 32'h1);
    checkOutput("lfsr_restart_done", 32'(seq_done), 0);
    for (int k = 0; k < 15; k++) begin
      runCycles(DIV);
      checkOutput("lfsr_pat", 32'(pat), 32'(lfsr_exp[k]));
      checkOutput("lfsr_done", 32'(seq_done), (k == 14) ? 1 : 0);
    end

    runCycles(5);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_pat", 32'(pat), 0);
    checkOutput("async_rst_step", 32'(step), 0);
    checkOutput("async_rst_seq_done", 32'(seq_done), 0);
    checkOutput("async_rst_sig", 32'(sig), 0);
    checkOutput("async_rst_sig_valid", 32'(sig_valid), 0);
    runCycles(2);
    rst = 1'b1;

    applyStimulus(2'd0, 1'b1, '0, '0);
    runCycles(1);
    runCycles(3 * DIV);
    checkOutput("freeze_start", 32'(pat), 32'hE);
    applyStimulus(2'd0, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      runCycles(1);
      checkOutput("freeze_hold", 32'(pat), 32'hE);
    end
    applyStimulus(2'd0, 1'b1, '0, '0);
    runCycles(DIV - 1);
    checkOutput("resume_wait", 32'(pat), 32'hE);
    runCycles(1);
    checkOutput("resume_pat", 32'(pat), 32'hF);

    runCycles(DIV - 1);
    applyStimulus(2'd1, 1'b1, '0, '0);
    runCycles(1);
    checkOutput("restart_vs_tick_pat", 32'(pat), 0);
    checkOutput("restart_vs_tick_step", 32'(step), 0);
    checkOutput("restart_vs_tick_done", 32'(seq_done), 0);

    applyStimulus(2'd3, 1'b1, '0, '0);
    runCycles(2);
    applyStimulus(2'd3, 1'b1, 4'b1010, '0);
    runCycles(1);
    checkOutput("load_pat_a", 32'(pat), 32'hA);
    applyStimulus(2'd3, 1'b0, 4'b0101, '0);
    runCycles(1);
    checkOutput("load_pat_b", 32'(pat), 32'h5);
    checkOutput("load_step", 32'(step), 0);
    checkOutput("load_done", 32'(seq_done), 0);

    applyStimulus(2'd1, 1'b1, '0, 4'b1111);
    runCycles(1);
    runCycles(5 * DIV);
    checkOutput("misr_sig_valid", 32'(sig_valid), 32'(MISR_ON));
    checkOutput("misr_sig", 32'(sig), 32'(MISR_SIG_EXP));
    runCycles(1);
    checkOutput("misr_pulse_end", 32'(sig_valid), 0);
    runCycles(5 * DIV - 1);
    checkOutput("misr_again_valid", 32'(sig_valid), 32'(MISR_ON));
    checkOutput("misr_again_sig", 32'(sig), 32'(MISR_SIG_EXP));

    applyStimulus(2'd0, 1'b1, '0, '0);
    for (int i = 0; i < 4000; i++) begin
      runCycles(1);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(299) == 0) rst = 1'b0;
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) en = ~en;
      sw = W'($urandom);
      resp = W'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
